maze_bfs_solver: RTL and testbench

- Parametrised successor to the team's fixed 17x17 BFS maze solver.
- Loads a ROWS x COLS bit-serial maze, runs a breadth-first search from (0,0) to (ROWS-1,COLS-1), backtracks, and streams the shortest path as 2-bit moves.
- New relative to the previous generation: rectangular size, input back-pressure, explicit "no path" and "queue overflow" outcomes, and an end-of-path marker.

---
 rtl/maze_bfs_solver.sv | 223 ++++++++++++++++++++++
 tb/tb_maze_bfs_solver.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_bfs_solver.sv
// Breadth-first maze solver. Loads a ROWS x COLS bit-serial maze and searches
// from (0,0) to (ROWS-1,COLS-1) with right/down/left/up neighbour order. It
// then backtracks through the parent moves and streams the shortest path.
// A failed search gives a single beat carrying status 1 (no path) or
// status 2 (frontier FIFO overflow).
module maze_bfs_solver #(
    parameter int ROWS     = 17,
    parameter int COLS     = 17,
    parameter int QDEPTH   = 32,
    parameter int MAX_PATH = ROWS*COLS-1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out,
    output logic       out_last,
    output logic [1:0] status
);
    localparam int NCELL = ROWS*COLS;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int IW    = $clog2(NCELL);
    localparam int QW    = $clog2(QDEPTH);
    localparam int CNW   = $clog2(QDEPTH+1);
    localparam int PW    = $clog2(MAX_PATH+1);

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, TRACE, OUTPUT, FAIL} state_t;

    state_t              state;
    logic [NCELL-1:0]    open_q;
    logic [NCELL-1:0]    vis_q;
    logic [1:0]          par_q  [NCELL];
    logic [RW+CW-1:0]    fifo_q [QDEPTH];
    logic [1:0]          path_q [MAX_PATH];
    logic [QW-1:0]       head_q, tail_q;
    logic [CNW-1:0]      cnt_q;
    logic [IW-1:0]       lcnt_q;
    logic [PW-1:0]       plen_q, rd_q;
    logic [RW-1:0]       cur_r, tr_r;
    logic [CW-1:0]       cur_c, tr_c;
    logic [1:0]          dir_q;
    logic                started_q;

    function automatic logic [IW-1:0] cidx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return IW'(int'(r) * COLS + int'(c));
    endfunction

    function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
        return (p == QW'(QDEPTH-1)) ? '0 : p + QW'(1);
    endfunction

    logic [RW-1:0]    nb_r, pr;
    logic [CW-1:0]    nb_c, pc;
    logic [IW-1:0]    nb_idx, tr_idx;
    logic             nb_in, nb_en, nb_goal;
    logic [1:0]       tm;
    logic             srch, ovf, do_push, hit, dead, do_pop;
    logic [RW+CW-1:0] nxt_cur;

    // Candidate neighbour of the current cell, with non-wrapping bounds checks
    always_comb begin
        nb_r  = cur_r;
        nb_c  = cur_c;
        nb_in = 1'b0;
        case (dir_q)
            2'd0: begin nb_in = (int'(cur_c) < COLS-1); nb_c = cur_c + CW'(1); end
            2'd1: begin nb_in = (int'(cur_r) < ROWS-1); nb_r = cur_r + RW'(1); end
            2'd2: begin nb_in = (cur_c != '0);          nb_c = cur_c - CW'(1); end
            default: begin nb_in = (cur_r != '0);       nb_r = cur_r - RW'(1); end
        endcase
        nb_idx  = cidx(nb_r, nb_c);
        nb_en   = nb_in && open_q[nb_idx] && !vis_q[nb_idx];
        nb_goal = (nb_r == RW'(ROWS-1)) && (nb_c == CW'(COLS-1));

        // A step that empties the FIFO while pushing must take the pushed cell
        nxt_cur = (cnt_q == '0) ? {nb_r, nb_c} : fifo_q[head_q];

        srch    = (state == SEARCH) && started_q;
        ovf     = srch && nb_en && (cnt_q == CNW'(QDEPTH));
        do_push = srch && nb_en && !ovf;
        hit     = do_push && nb_goal;
        dead    = srch && !ovf && !hit && (dir_q == 2'd3) && (cnt_q == '0) && !nb_en;
        do_pop  = srch && !ovf && !hit && (dir_q == 2'd3) && !dead;

        // Backtrack step: undo the move that entered the trace cell
        tr_idx = cidx(tr_r, tr_c);
        tm     = par_q[tr_idx];
        pr     = tr_r;
        pc     = tr_c;
        case (tm)
            2'd0:    pc = tr_c - CW'(1);
            2'd1:    pr = tr_r - RW'(1);
            2'd2:    pc = tr_c + CW'(1);
            default: pr = tr_r + RW'(1);
        endcase
    end

    // Controller: load, search, trace, stream; all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= 2'd0;
            out_last  <= 1'b0;
            status    <= 2'd0;
            vis_q     <= '0;
            for (int i = 0; i < NCELL; i++) par_q[i] <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            lcnt_q    <= '0;
            plen_q    <= '0;
            rd_q      <= '0;
            started_q <= 1'b0;
            dir_q     <= 2'd0;
            cur_r     <= '0;
            cur_c     <= '0;
            tr_r      <= '0;
            tr_c      <= '0;
        end else begin
            if (do_push) begin
                fifo_q[tail_q]  <= {nb_r, nb_c};
                tail_q          <= qinc(tail_q);
                vis_q[nb_idx]   <= 1'b1;
                par_q[nb_idx]   <= dir_q;
            end
            if (do_pop) head_q <= qinc(head_q);
            cnt_q <= cnt_q + CNW'(do_push) - CNW'(do_pop);

            case (state)
                IDLE, LOAD: begin
                    if (in_valid) begin
                        open_q[lcnt_q] <= in;
                        if (lcnt_q == IW'(NCELL-1)) begin
                            state     <= SEARCH;
                            in_ready  <= 1'b0;
                            lcnt_q    <= '0;
                            started_q <= 1'b0;
                        end else begin
                            state  <= LOAD;
                            lcnt_q <= lcnt_q + IW'(1);
                        end
                    end
                end
                SEARCH: begin
                    if (!started_q) begin
                        if (!open_q[0] || !open_q[NCELL-1]) begin
                            state     <= FAIL;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                            out       <= 2'd0;
                            status    <= 2'd1;
                        end else begin
                            vis_q[0]  <= 1'b1;
                            cur_r     <= '0;
                            cur_c     <= '0;
                            dir_q     <= 2'd0;
                            started_q <= 1'b1;
                        end
                    end else if (ovf || dead) begin
                        state     <= FAIL;
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out       <= 2'd0;
                        status    <= ovf ? 2'd2 : 2'd1;
                    end else if (hit) begin
                        state  <= TRACE;
                        tr_r   <= RW'(ROWS-1);
                        tr_c   <= CW'(COLS-1);
                        plen_q <= '0;
                    end else if (do_pop) begin
                        {cur_r, cur_c} <= nxt_cur;
                        dir_q          <= 2'd0;
                    end else begin
                        dir_q <= dir_q + 2'd1;
                    end
                end
                TRACE: begin
                    path_q[plen_q] <= tm;
                    plen_q         <= plen_q + PW'(1);
                    tr_r           <= pr;
                    tr_c           <= pc;
                    if (pr == '0 && pc == '0) begin
                        state     <= OUTPUT;
                        out_valid <= 1'b1;
                        out       <= tm;
                        out_last  <= (plen_q == '0);
                        status    <= 2'd0;
                        rd_q      <= plen_q;
                    end
                end
                OUTPUT, FAIL: begin
                    if (state == OUTPUT && !out_last) begin
                        rd_q     <= rd_q - PW'(1);
                        out      <= path_q[rd_q - PW'(1)];
                        out_last <= (rd_q == PW'(1));
                    end else begin
                        // Wipe search state on the way out so the next maze loads at once
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out       <= 2'd0;
                        out_last  <= 1'b0;
                        status    <= 2'd0;
                        vis_q     <= '0;
                        for (int i = 0; i < NCELL; i++) par_q[i] <= 2'd0;
                        head_q    <= '0;
                        tail_q    <= '0;
                        cnt_q     <= '0;
                        lcnt_q    <= '0;
                        plen_q    <= '0;
                        started_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_bfs_solver.sv
// Bench for maze_bfs_solver: fixed and random mazes compared with a software BFS.
module tb_maze_bfs_solver;
    localparam int R = 17, C = 17, N = R*C;
    localparam int LAT_MAX = 4*N + (N-1) + 4;

    logic clk = 0, rst_n = 0;
    logic in_valid = 0, in_bit = 0, in_ready, out_valid, out_last;
    logic [1:0] out_mv, status;
    logic s_in_valid = 0, s_in = 0, s_in_ready, s_out_valid, s_out_last;
    logic [1:0] s_out, s_status;

    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    maze_bfs_solver #(.ROWS(17), .COLS(17), .QDEPTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_bit), .in_ready(in_ready),
        .out_valid(out_valid), .out(out_mv), .out_last(out_last), .status(status));

    maze_bfs_solver #(.ROWS(4), .COLS(9), .QDEPTH(2)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in(s_in), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out(s_out), .out_last(s_out_last), .status(s_status));

    // Software BFS: pop current, visit R/D/L/U, bounded queue, then backtrack
    task automatic ref_bfs(input int rr, input int cc, input int q, input bit m[],
                           output int st, output int mv[$]);
        bit vis[];
        int par[];
        int fq[$];
        int dr[4] = '{0, 1, 0, -1};
        int dc[4] = '{1, 0, -1, 0};
        int cur, n, nr, nc;
        mv = {};
        st = 0;
        if (!m[0] || !m[rr*cc-1]) begin st = 1; return; end
        vis = new[rr*cc];
        par = new[rr*cc];
        vis[0] = 1;
        cur = 0;
        while (1) begin
            for (int d = 0; d < 4; d++) begin
                nr = cur / cc + dr[d];
                nc = cur % cc + dc[d];
                if (nr < 0 || nr >= rr || nc < 0 || nc >= cc) continue;
                n = nr*cc + nc;
                if (!m[n] || vis[n]) continue;
                if (fq.size() == q) begin st = 2; return; end
                vis[n] = 1;
                par[n] = d;
                fq.push_back(n);
                if (n == rr*cc-1) begin
                    while (n != 0) begin
                        mv.push_front(par[n]);
                        case (par[n])
                            0: n = n - 1;
                            1: n = n - cc;
                            2: n = n + 1;
                            default: n = n + cc;
                        endcase
                    end
                    return;
                end
            end
            if (fq.size() == 0) begin st = 1; return; end
            cur = fq.pop_front();
        end
    endtask

    task automatic load_big(input bit m[], input int gapmax);
        int g;
        for (int i = 0; i < N; i++) begin
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            in_valid = 0;
            repeat (g) begin @(posedge clk); #1; end
            in_valid = 1;
            in_bit = m[i];
            @(posedge clk); #1;
        end
        in_valid = 0;
    endtask

    // Wait for the result, collect it and compare with the software BFS
    task automatic check_big(input string name, input bit m[], input int maxlat,
                             output int got_st, output int got[$]);
        int est, emv[$], lat, elen;
        bit gap, sawlast, lastbad, stbad;
        got = {};
        got_st = -1;
        ref_bfs(R, C, 32, m, est, emv);
        lat = 0;
        while (!out_valid && lat < 3000) begin @(posedge clk); #1; lat++; end
        checks++;
        if (!out_valid) begin
            errs++;
            $display("FAIL %s timeout: no out_valid after %0d cycles", name, lat);
            return;
        end
        checks++;
        if (lat > maxlat) begin
            errs++;
            $display("FAIL %s latency: got %0d cycles, limit %0d", name, lat, maxlat);
        end
        got_st = int'(status);
        gap = 0; sawlast = 0; lastbad = 0; stbad = 0;
        for (int k = 0; k < N + 4; k++) begin
            if (!out_valid) begin gap = 1; break; end
            got.push_back(int'(out_mv));
            if (int'(status) != got_st) stbad = 1;
            if (out_last) begin sawlast = 1; @(posedge clk); #1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (got_st != est || stbad) begin
            errs++;
            $display("FAIL %s status: got %0d (changing=%0d), expected %0d", name, got_st, stbad, est);
        end
        elen = (est == 0) ? emv.size() : 1;
        checks++;
        if (got.size() != elen) begin
            errs++;
            $display("FAIL %s length: got %0d beats, expected %0d", name, got.size(), elen);
        end else begin
            for (int k = 0; k < elen; k++) begin
                if (got[k] != ((est == 0) ? emv[k] : 0)) begin
                    errs++;
                    $display("FAIL %s move %0d: got %0d, expected %0d", name, k, got[k],
                             (est == 0) ? emv[k] : 0);
                    break;
                end
            end
            checks++;
        end
        if (!sawlast || gap) lastbad = 1;
        checks++;
        if (lastbad) begin
            errs++;
            $display("FAIL %s framing: out_last seen=%0d, gap=%0d", name, sawlast, gap);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s after-result: out_valid=%b in_ready=%b, expected 0/1", name, out_valid, in_ready);
        end
    endtask

    function automatic void rand_maze(output bit m[]);
        m = new[N];
        foreach (m[i]) m[i] = ($urandom_range(99, 0) < 78);
        m[0] = 1;
        m[N-1] = 1;
    endfunction

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 0 || out_mv !== 0 || out_last !== 0 || status !== 0 || in_ready !== 1) begin
            errs++;
            $display("FAIL reset big: v=%b o=%0d l=%b s=%0d rdy=%b, expected 0/0/0/0/1",
                     out_valid, out_mv, out_last, status, in_ready);
        end
        checks++;
        if (s_out_valid !== 0 || s_out !== 0 || s_out_last !== 0 || s_status !== 0 || s_in_ready !== 1) begin
            errs++;
            $display("FAIL reset small: v=%b o=%0d l=%b s=%0d rdy=%b, expected 0/0/0/0/1",
                     s_out_valid, s_out, s_out_last, s_status, s_in_ready);
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_corridor;
        bit m[];
        int st, got[$];
        m = new[N];
        for (int i = 0; i < N; i++) m[i] = (i / C == 0) || (i % C == C-1);
        load_big(m, 0);
        check_big("corridor", m, LAT_MAX, st, got);
        checks++;
        if (got.size() != 32 || got[0] != 0 || got[15] != 0 || got[16] != 1 || got[31] != 1) begin
            errs++;
            $display("FAIL corridor shape: got %0d beats, expected 16 rights then 16 downs", got.size());
        end
    endtask

    task automatic test_all_open;
        bit m[];
        int st, got[$], nr, nd;
        m = new[N];
        foreach (m[i]) m[i] = 1;
        load_big(m, 0);
        check_big("all_open", m, LAT_MAX, st, got);
        nr = 0; nd = 0;
        foreach (got[i]) begin
            if (got[i] == 0) nr++;
            if (got[i] == 1) nd++;
        end
        checks++;
        if (nr != 16 || nd != 16 || st != 0) begin
            errs++;
            $display("FAIL all_open counts: rights=%0d downs=%0d status=%0d, expected 16/16/0", nr, nd, st);
        end
    endtask

    task automatic test_goal_wall;
        bit m[];
        int st, got[$];
        rand_maze(m);
        m[N-1] = 0;
        load_big(m, 1);
        check_big("goal_wall", m, 3, st, got);
    endtask

    task automatic test_back_to_back;
        bit m[];
        int st, got[$];
        m = new[N];
        foreach (m[i]) m[i] = (i / C != 8);
        load_big(m, 0);
        check_big("row_wall", m, LAT_MAX, st, got);
        checks++;
        if (st != 1) begin
            errs++;
            $display("FAIL row_wall status: got %0d, expected 1", st);
        end
        foreach (m[i]) m[i] = 1;
        load_big(m, 0);
        check_big("b2b_open", m, LAT_MAX, st, got);
    endtask

    task automatic test_overflow;
        int lat;
        for (int i = 0; i < 36; i++) begin
            s_in_valid = 1;
            s_in = 1;
            @(posedge clk); #1;
        end
        s_in_valid = 0;
        lat = 0;
        while (!s_out_valid && lat < 500) begin @(posedge clk); #1; lat++; end
        checks++;
        if (s_out_valid !== 1 || s_out_last !== 1 || s_status !== 2 || s_out !== 0) begin
            errs++;
            $display("FAIL overflow beat: v=%b l=%b s=%0d o=%0d, expected 1/1/2/0",
                     s_out_valid, s_out_last, s_status, s_out);
        end
        @(posedge clk); #1;
        checks++;
        if (s_out_valid !== 0 || s_in_ready !== 1) begin
            errs++;
            $display("FAIL overflow after: v=%b rdy=%b, expected 0/1", s_out_valid, s_in_ready);
        end
    endtask

    task automatic test_random;
        bit m[];
        int st, got[$];
        for (int t = 0; t < 3; t++) begin
            rand_maze(m);
            load_big(m, 2);
            check_big($sformatf("random%0d", t), m, LAT_MAX, st, got);
        end
    endtask

    task automatic test_reset_mid;
        bit m[];
        int st, got[$], lat;
        m = new[N];
        foreach (m[i]) m[i] = 1;
        load_big(m, 1);
        repeat (40) begin @(posedge clk); #1; end
        rst_n = 0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 0 || out_mv !== 0 || out_last !== 0 || status !== 0 || in_ready !== 1) begin
            errs++;
            $display("FAIL reset_search: v=%b o=%0d l=%b s=%0d rdy=%b, expected 0/0/0/0/1",
                     out_valid, out_mv, out_last, status, in_ready);
        end
        rst_n = 1;
        load_big(m, 1);
        lat = 0;
        while (!out_valid && lat < 3000) begin @(posedge clk); #1; lat++; end
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 0;
        @(posedge clk); #1;
        checks++;
        if (lat >= 3000 || out_valid !== 0 || out_mv !== 0 || out_last !== 0 || status !== 0 || in_ready !== 1) begin
            errs++;
            $display("FAIL reset_output: wait=%0d v=%b o=%0d l=%b s=%0d rdy=%b, expected 0/0/0/0/1",
                     lat, out_valid, out_mv, out_last, status, in_ready);
        end
        rst_n = 1;
        rand_maze(m);
        load_big(m, 3);
        check_big("reload", m, LAT_MAX, st, got);
    endtask

    initial begin
        test_reset;
        test_corridor;
        test_all_open;
        test_goal_wall;
        test_back_to_back;
        test_overflow;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
